multicycle_adder: RTL and testbench

//  WIDTH-bit adder/subtractor that processes the operands one CHUNK-bit slice per clock.
//  The carry is held in a register between slices, so one CHUNK-bit full-adder datapath

---
 rtl/multicycle_adder.sv | 123 ++++++++++++
 tb/tb_multicycle_adder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_adder.sv
// rtl/multicycle_adder.sv - serial adder/subtractor, one CHUNK-bit slice per clock
// Carry is held between slices so a single CHUNK-bit adder covers the full WIDTH.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CHUNK-1:0]  a_sl, b_sl;
  logic [CHUNK:0]    sum_w;
  logic              last;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    a_sl  = a_q[idx_q*CHUNK +: CHUNK];
    b_sl  = b_q[idx_q*CHUNK +: CHUNK];
    sum_w = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK+1)'(carry_q);
    last  = (idx_q == IW'(NCH - 1));

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          // Subtraction is a + ~b + 1; the stored B is already inverted.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        s_d[idx_q*CHUNK +: CHUNK] = sum_w[CHUNK-1:0];
        carry_d = sum_w[CHUNK];
        idx_d   = idx_q + IW'(1);
        if (last) begin
          cout_d  = sum_w[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[CHUNK-1] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// tb/tb_multicycle_adder.sv - directed and random checks of multicycle_adder
// Three instances: 16/4 (main), 8/8 (single slice), 32/8 (random compare).
module tb_multicycle_adder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic        st16 = 0, sb16 = 0, ci16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        busy16, done16, co16, ov16;
  logic [15:0] s16;

  logic        st8 = 0, sb8 = 0, ci8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic        busy8, done8, co8, ov8;
  logic [7:0]  s8;

  logic        st32 = 0, sb32 = 0, ci32 = 0;
  logic [31:0] a32 = 0, b32 = 0;
  logic        busy32, done32, co32, ov32;
  logic [31:0] s32;

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .reset(reset), .start(st16), .sub(sb16), .a(a16), .b(b16), .cin(ci16),
    .busy(busy16), .done(done16), .s(s16), .cout(co16), .ovf(ov16));

  multicycle_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset), .start(st8), .sub(sb8), .a(a8), .b(b8), .cin(ci8),
    .busy(busy8), .done(done8), .s(s8), .cout(co8), .ovf(ov8));

  multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .reset(reset), .start(st32), .sub(sb32), .a(a32), .b(b32), .cin(ci32),
    .busy(busy32), .done(done32), .s(s32), .cout(co32), .ovf(ov32));

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Request at the next edge, then count edges until done; busy counted per cycle.
  task automatic op16(input logic sb, input logic [15:0] aa, input logic [15:0] bb,
                      input logic ci, output int lat, output int bcnt);
    @(negedge clk);
    st16 = 1; sb16 = sb; a16 = aa; b16 = bb; ci16 = ci;
    @(posedge clk); #1;
    st16 = 0; a16 = ~aa; b16 = ~bb; sb16 = ~sb;
    lat = 0; bcnt = 0;
    while (!done16 && lat < 20) begin
      if (busy16) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op8(input logic [7:0] aa, input logic [7:0] bb, output int lat, output int bcnt);
    @(negedge clk);
    st8 = 1; sb8 = 0; a8 = aa; b8 = bb; ci8 = 0;
    @(posedge clk); #1;
    st8 = 0;
    lat = 0; bcnt = 0;
    while (!done8 && lat < 20) begin
      if (busy8) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op32(input logic sb, input logic [31:0] aa, input logic [31:0] bb,
                      input logic ci, output int lat);
    @(negedge clk);
    st32 = 1; sb32 = sb; a32 = aa; b32 = bb; ci32 = ci;
    @(posedge clk); #1;
    st32 = 0;
    lat = 0;
    while (!done32 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt;
    logic [15:0] ea, eb;
    logic [15:0] exp_q[$];

    vecs[0] = '{0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1};
    vecs[1] = '{0, 16'hFFFF, 16'h0000, 1, 16'h0000, 1, 0};
    vecs[2] = '{1, 16'h0003, 16'h0005, 0, 16'hFFFE, 0, 0};
    vecs[3] = '{1, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 1};
    vecs[4] = '{1, 16'h0003, 16'h0005, 1, 16'hFFFE, 0, 0};
    vecs[5] = '{1, 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1};
    vecs[6] = '{0, 16'h1234, 16'h1111, 0, 16'h2345, 0, 0};
    vecs[7] = '{0, 16'h8000, 16'h8000, 0, 16'h0000, 1, 1};
    vecs[8] = '{1, 16'h0005, 16'h0005, 0, 16'h0000, 1, 0};
    vecs[9] = '{0, 16'h00FF, 16'h0001, 0, 16'h0100, 0, 0};

    #1 reset = 1;
    #1;
    chk("rst_busy", busy16, 0);
    chk("rst_done", done16, 0);
    chk("rst_s", s16, 0);
    chk("rst_cout", co16, 0);
    chk("rst_ovf", ov16, 0);
    @(negedge clk); reset = 0;

    // Table of directed vectors, each also checks latency and busy length.
    for (int i = 0; i < 10; i++) begin
      op16(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt);
      chk($sformatf("v%0d_lat", i), lat, 4);
      chk($sformatf("v%0d_busy", i), bcnt, 4);
      chk($sformatf("v%0d_s", i), s16, vecs[i].s);
      chk($sformatf("v%0d_cout", i), co16, vecs[i].cout);
      chk($sformatf("v%0d_ovf", i), ov16, vecs[i].ovf);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", done16, 0);
    chk("hold_s_idle", s16, 16'h0100);

    // start held high: accepts at cycles 0,5,10,15 with operands of that cycle.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      st16 = 1; sb16 = 0; ci16 = 0;
      ea = 16'(c * 16'h0123 + 7);
      eb = 16'(c * 16'h0311 + 1);
      a16 = ea; b16 = eb;
      if (c % 5 == 0) exp_q.push_back(ea + eb);
      @(posedge clk); #1;
      chk($sformatf("b2b_nboth_%0d", c), busy16 & done16, 0);
      if (c % 5 == 4) begin
        chk($sformatf("b2b_done_%0d", c), done16, 1);
        chk($sformatf("b2b_s_%0d", c), s16, exp_q.pop_front());
      end else begin
        chk($sformatf("b2b_ndone_%0d", c), done16, 0);
      end
    end
    @(negedge clk); st16 = 0;
    @(posedge clk); #1;

    // Abort during slice 2.
    @(negedge clk);
    st16 = 1; sb16 = 0; ci16 = 0; a16 = 16'h7777; b16 = 16'h1111;
    @(posedge clk); #1; st16 = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("abort_busy_pre", busy16, 1);
    chk("abort_slices01", s16[7:0], 8'h88);
    reset = 1;
    #1;
    chk("abort_busy", busy16, 0);
    chk("abort_done", done16, 0);
    chk("abort_s", s16, 0);
    chk("abort_cout", co16, 0);
    chk("abort_ovf", ov16, 0);
    @(negedge clk); reset = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_nodone_%0d", k), done16, 0);
    end
    op16(0, 16'h1234, 16'h1111, 0, lat, bcnt);
    chk("post_abort_lat", lat, 4);
    chk("post_abort_s", s16, 16'h2345);

    // Single-slice configuration.
    op8(8'hFF, 8'h01, lat, bcnt);
    chk("w8_lat", lat, 1);
    chk("w8_busy", bcnt, 1);
    chk("w8_s", s8, 8'h00);
    chk("w8_cout", co8, 1);
    chk("w8_ovf", ov8, 0);

    // Random compare on 32/8.
    for (int i = 0; i < 1000; i++) begin
      logic        rs, rc;
      logic [31:0] ra, rb, beff;
      logic [32:0] full;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (i == 0) begin ra = 32'hFFFFFFFF; rb = 32'h0; rs = 0; rc = 1; end
      if (rs) full = {1'b0, ra} - {1'b0, rb} + 33'h1_0000_0000;
      else    full = {1'b0, ra} + {1'b0, rb} + 33'(rc);
      beff = rs ? ~rb : rb;
      op32(rs, ra, rb, rc, lat);
      chk($sformatf("r%0d_lat", i), lat, 4);
      chk($sformatf("r%0d_s", i), s32, full[31:0]);
      chk($sformatf("r%0d_cout", i), co32, full[32]);
      chk($sformatf("r%0d_ovf", i), ov32,
          (ra[31] == beff[31]) && (full[31] != ra[31]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
